// File: rtl/minisrc_pkg.sv
// Shared definitions for the Mini SRC control path: opcodes, ALU codes,
// step states, decode classes and the control-word layout.
package minisrc_pkg;

    localparam int OPC_W = 5;
    localparam int ALU_W = 5;

    localparam logic [OPC_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OPC_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPC_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPC_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OPC_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OPC_W-1:0] OP_SHR  = 5'b00111;
    localparam logic [OPC_W-1:0] OP_SHRA = 5'b01000;
    localparam logic [OPC_W-1:0] OP_SHL  = 5'b01001;
    localparam logic [OPC_W-1:0] OP_ROR  = 5'b01010;
    localparam logic [OPC_W-1:0] OP_ROL  = 5'b01011;
    localparam logic [OPC_W-1:0] OP_ADDI = 5'b01100;
    localparam logic [OPC_W-1:0] OP_ANDI = 5'b01101;
    localparam logic [OPC_W-1:0] OP_ORI  = 5'b01110;
    localparam logic [OPC_W-1:0] OP_MUL  = 5'b01111;
    localparam logic [OPC_W-1:0] OP_DIV  = 5'b10000;
    localparam logic [OPC_W-1:0] OP_NEG  = 5'b10001;
    localparam logic [OPC_W-1:0] OP_NOT  = 5'b10010;
    localparam logic [OPC_W-1:0] OP_BR   = 5'b10011;
    localparam logic [OPC_W-1:0] OP_JR   = 5'b10100;
    localparam logic [OPC_W-1:0] OP_IN   = 5'b10110;
    localparam logic [OPC_W-1:0] OP_OUT  = 5'b10111;
    localparam logic [OPC_W-1:0] OP_MFHI = 5'b11000;
    localparam logic [OPC_W-1:0] OP_MFLO = 5'b11001;
    localparam logic [OPC_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

    localparam logic [ALU_W-1:0] ALU_ADD = 5'b00011;
    localparam logic [ALU_W-1:0] ALU_AND = 5'b00101;
    localparam logic [ALU_W-1:0] ALU_OR  = 5'b00110;

    typedef enum logic [3:0] {
        ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
    } step_e;

    typedef enum logic [3:0] {
        CLS_NOP, CLS_REG, CLS_IMM, CLS_LDI, CLS_LD, CLS_ST, CLS_MULDIV,
        CLS_UNARY, CLS_BR, CLS_JR, CLS_IN, CLS_OUT, CLS_MFHI, CLS_MFLO, CLS_HALT
    } op_class_e;

    typedef struct packed {
        op_class_e        cls;
        logic [ALU_W-1:0] alu;
        step_e            last_step;
    } decode_t;

    typedef struct packed {
        logic pc_in, ir_in, y_in, z_in, hi_in, lo_in, mar_in, mdr_in, outport_in, con_in;
        logic pc_out, zhigh_out, zlow_out, hi_out, lo_out, mdr_out, inport_out, c_out;
        logic gra, grb, grc, rin, rout, baout;
        logic inc_pc, read, write;
        logic [ALU_W-1:0] alu;
        logic run;
    } ctrl_t;

    function automatic logic [OPC_W-1:0] ir_opcode(input logic [31:0] ir);
        return ir[31:27];
    endfunction

    // Execute steps advance linearly; anything past T7 wraps to T0.
    function automatic step_e step_after(input step_e s);
        case (s)
            ST_T3:   return ST_T4;
            ST_T4:   return ST_T5;
            ST_T5:   return ST_T6;
            ST_T6:   return ST_T7;
            default: return ST_T0;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Bundle between the control unit and the datapath: instruction/condition
// inputs plus every strobe the sequencer produces.
interface control_unit_if;
    import minisrc_pkg::*;

    logic [31:0] IR_Data;
    logic        CON_out;

    logic PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, CON_in;
    logic PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out;
    logic Gra, Grb, Grc, Rin, Rout, BAout;
    logic IncPC, Read, Write;
    logic [ALU_W-1:0] alu_instruction_bits;
    logic Run;

    modport master (
        input  IR_Data, CON_out,
        output PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, CON_in,
        output PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out,
        output Gra, Grb, Grc, Rin, Rout, BAout, IncPC, Read, Write,
        output alu_instruction_bits, Run
    );

    modport slave (
        output IR_Data, CON_out,
        input  PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, CON_in,
        input  PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out,
        input  Gra, Grb, Grc, Rin, Rout, BAout, IncPC, Read, Write,
        input  alu_instruction_bits, Run
    );

endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier: instruction class, ALU code to issue and
// the final execute step of the instruction.
module ctrl_decode
    import minisrc_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output decode_t          dec
);

    always_comb begin
        dec.cls       = CLS_NOP;
        dec.alu       = '0;
        dec.last_step = ST_T2;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL: begin
                dec.cls       = CLS_REG;
                dec.alu       = opcode;
                dec.last_step = ST_T5;
            end
            OP_ADDI: begin
                dec.cls       = CLS_IMM;
                dec.alu       = ALU_ADD;
                dec.last_step = ST_T5;
            end
            OP_ANDI: begin
                dec.cls       = CLS_IMM;
                dec.alu       = ALU_AND;
                dec.last_step = ST_T5;
            end
            OP_ORI: begin
                dec.cls       = CLS_IMM;
                dec.alu       = ALU_OR;
                dec.last_step = ST_T5;
            end
            OP_LDI: begin
                dec.cls       = CLS_LDI;
                dec.alu       = ALU_ADD;
                dec.last_step = ST_T5;
            end
            OP_LD: begin
                dec.cls       = CLS_LD;
                dec.alu       = ALU_ADD;
                dec.last_step = ST_T7;
            end
            OP_ST: begin
                dec.cls       = CLS_ST;
                dec.alu       = ALU_ADD;
                dec.last_step = ST_T7;
            end
            OP_MUL, OP_DIV: begin
                dec.cls       = CLS_MULDIV;
                dec.alu       = opcode;
                dec.last_step = ST_T6;
            end
            OP_NEG, OP_NOT: begin
                dec.cls       = CLS_UNARY;
                dec.alu       = opcode;
                dec.last_step = ST_T4;
            end
            OP_BR: begin
                dec.cls       = CLS_BR;
                dec.alu       = ALU_ADD;
                dec.last_step = ST_T6;
            end
            OP_JR: begin
                dec.cls       = CLS_JR;
                dec.last_step = ST_T3;
            end
            OP_IN: begin
                dec.cls       = CLS_IN;
                dec.last_step = ST_T3;
            end
            OP_OUT: begin
                dec.cls       = CLS_OUT;
                dec.last_step = ST_T3;
            end
            OP_MFHI: begin
                dec.cls       = CLS_MFHI;
                dec.last_step = ST_T3;
            end
            OP_MFLO: begin
                dec.cls       = CLS_MFLO;
                dec.last_step = ST_T3;
            end
            OP_HALT: dec.cls = CLS_HALT;
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Moore step sequencer for the Mini SRC: fetch T0-T2, class-specific
// execute steps T3-T7, plus reset and halt states.
module control_unit
    import minisrc_pkg::*;
(
    input  logic           clk,
    input  logic           clr,
    control_unit_if.master bus
);

    step_e            state_q, state_d;
    logic [OPC_W-1:0] opcode_q, opcode_d;
    logic             con_q, con_d;
    logic [OPC_W-1:0] dec_opcode;
    decode_t          dec;
    ctrl_t            ctrl;
    logic             unused_ir;

    assign unused_ir = ^bus.IR_Data[26:0];

    // During T2 the branch out of fetch is decided from the live IR; after
    // that everything runs off the opcode captured on the way into T3.
    assign dec_opcode = (state_q == ST_T2) ? ir_opcode(bus.IR_Data) : opcode_q;

    ctrl_decode u_decode (
        .opcode (dec_opcode),
        .dec    (dec)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= ST_RST;
            opcode_q <= '0;
            con_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            con_q    <= con_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        con_d    = con_q;
        case (state_q)
            ST_RST: state_d = ST_T0;
            ST_T0:  state_d = ST_T1;
            ST_T1:  state_d = ST_T2;
            ST_T2: begin
                opcode_d = ir_opcode(bus.IR_Data);
                if (dec.cls == CLS_HALT)
                    state_d = ST_HALT;
                else if (dec.last_step == ST_T2)
                    state_d = ST_T0;
                else
                    state_d = ST_T3;
            end
            ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
                // Branch condition is frozen on entry to T6 so PC_in stays Moore.
                if (state_q == ST_T5)
                    con_d = bus.CON_out;
                state_d = (state_q == dec.last_step) ? ST_T0 : step_after(state_q);
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RST;
        endcase
    end

    always_comb begin
        ctrl     = '0;
        ctrl.run = (state_q != ST_HALT);
        case (state_q)
            ST_T0: begin
                ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1; ctrl.inc_pc = 1'b1; ctrl.z_in = 1'b1;
            end
            ST_T1: begin
                ctrl.zlow_out = 1'b1; ctrl.pc_in = 1'b1; ctrl.read = 1'b1; ctrl.mdr_in = 1'b1;
            end
            ST_T2: begin
                ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1;
            end
            ST_T3: begin
                case (dec.cls)
                    CLS_REG, CLS_IMM: begin
                        ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.y_in = 1'b1;
                    end
                    CLS_LDI, CLS_LD, CLS_ST: begin
                        ctrl.grb = 1'b1; ctrl.baout = 1'b1; ctrl.y_in = 1'b1;
                    end
                    CLS_MULDIV: begin
                        ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.y_in = 1'b1;
                    end
                    CLS_UNARY: begin
                        ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.z_in = 1'b1; ctrl.alu = dec.alu;
                    end
                    CLS_BR: begin
                        ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.con_in = 1'b1;
                    end
                    CLS_JR: begin
                        ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.pc_in = 1'b1;
                    end
                    CLS_IN: begin
                        ctrl.inport_out = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1;
                    end
                    CLS_OUT: begin
                        ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.outport_in = 1'b1;
                    end
                    CLS_MFHI: begin
                        ctrl.hi_out = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1;
                    end
                    CLS_MFLO: begin
                        ctrl.lo_out = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T4: begin
                case (dec.cls)
                    CLS_REG: begin
                        ctrl.grc = 1'b1; ctrl.rout = 1'b1; ctrl.z_in = 1'b1; ctrl.alu = dec.alu;
                    end
                    CLS_IMM, CLS_LDI, CLS_LD, CLS_ST: begin
                        ctrl.c_out = 1'b1; ctrl.z_in = 1'b1; ctrl.alu = dec.alu;
                    end
                    CLS_MULDIV: begin
                        ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.z_in = 1'b1; ctrl.alu = dec.alu;
                    end
                    CLS_UNARY: begin
                        ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1;
                    end
                    CLS_BR: begin
                        ctrl.pc_out = 1'b1; ctrl.y_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (dec.cls)
                    CLS_REG, CLS_IMM, CLS_LDI: begin
                        ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1;
                    end
                    CLS_LD, CLS_ST: begin
                        ctrl.zlow_out = 1'b1; ctrl.mar_in = 1'b1;
                    end
                    CLS_MULDIV: begin
                        ctrl.zlow_out = 1'b1; ctrl.lo_in = 1'b1;
                    end
                    CLS_BR: begin
                        ctrl.c_out = 1'b1; ctrl.z_in = 1'b1; ctrl.alu = dec.alu;
                    end
                    default: ;
                endcase
            end
            ST_T6: begin
                case (dec.cls)
                    CLS_LD: begin
                        ctrl.read = 1'b1; ctrl.mdr_in = 1'b1;
                    end
                    CLS_ST: begin
                        ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.mdr_in = 1'b1;
                    end
                    CLS_MULDIV: begin
                        ctrl.zhigh_out = 1'b1; ctrl.hi_in = 1'b1;
                    end
                    CLS_BR: begin
                        ctrl.zlow_out = 1'b1; ctrl.pc_in = con_q;
                    end
                    default: ;
                endcase
            end
            ST_T7: begin
                case (dec.cls)
                    CLS_LD: begin
                        ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1;
                    end
                    CLS_ST: ctrl.write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign bus.PC_in                = ctrl.pc_in;
    assign bus.IR_in                = ctrl.ir_in;
    assign bus.Y_in                 = ctrl.y_in;
    assign bus.Z_in                 = ctrl.z_in;
    assign bus.HI_in                = ctrl.hi_in;
    assign bus.LO_in                = ctrl.lo_in;
    assign bus.MAR_in               = ctrl.mar_in;
    assign bus.MDR_in               = ctrl.mdr_in;
    assign bus.OutPort_in           = ctrl.outport_in;
    assign bus.CON_in               = ctrl.con_in;
    assign bus.PC_out               = ctrl.pc_out;
    assign bus.Zhigh_out            = ctrl.zhigh_out;
    assign bus.Zlow_out             = ctrl.zlow_out;
    assign bus.HI_out               = ctrl.hi_out;
    assign bus.LO_out               = ctrl.lo_out;
    assign bus.MDR_out              = ctrl.mdr_out;
    assign bus.InPort_out           = ctrl.inport_out;
    assign bus.C_out                = ctrl.c_out;
    assign bus.Gra                  = ctrl.gra;
    assign bus.Grb                  = ctrl.grb;
    assign bus.Grc                  = ctrl.grc;
    assign bus.Rin                  = ctrl.rin;
    assign bus.Rout                 = ctrl.rout;
    assign bus.BAout                = ctrl.baout;
    assign bus.IncPC                = ctrl.inc_pc;
    assign bus.Read                 = ctrl.read;
    assign bus.Write                = ctrl.write;
    assign bus.alu_instruction_bits = ctrl.alu;
    assign bus.Run                  = ctrl.run;

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk input 1 system clock, all state changes on posedge; clr input 1 reset.
REQ-002 IR_Data input 32 SHALL be the instruction register contents: opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15].
REQ-003 CON_out input 1 SHALL be the branch condition from the CON FF.
REQ-004 PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, CON_in output 1 each SHALL be the register load strobes.
REQ-005 PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out output 1 each SHALL be the bus drive strobes.
REQ-006 Gra, Grb, Grc, Rin, Rout, BAout output 1 each SHALL be the select/encode controls; IncPC, Read, Write output 1 each SHALL be the PC and memory controls.
REQ-007 alu_instruction_bits output 5 SHALL be the ALU operation code.
REQ-008 Run output 1 SHALL be high while executing and low when halted.

Function
REQ-009 The block SHALL be a Moore step sequencer with states RST, T0..T7 and HALT; outputs depend only on state and latched IR_Data/CON_out; all outputs not listed for a step are 0.
REQ-010 Fetch SHALL take one step per clock: T0 PC_out, MAR_in, IncPC, Z_in; T1 Zlow_out, PC_in, Read, MDR_in; T2 MDR_out, IR_in.
REQ-011 Opcode SHALL be sampled from IR_Data at T3 entry and held to instruction end.
REQ-012 Reg ALU ops (00011-01011): T3 Grb, Rout, Y_in; T4 Grc, Rout, Z_in, alu=opcode; T5 Zlow_out, Gra, Rin.
REQ-013 addi/andi/ori (01100/01101/01110): T3 Grb, Rout, Y_in; T4 C_out, Z_in, alu=00011/00101/00110; T5 Zlow_out, Gra, Rin.
REQ-014 ldi (00001): T3 Grb, BAout, Y_in; T4 C_out, Z_in, alu=00011; T5 Zlow_out, Gra, Rin.
REQ-015 ld (00000): T3-T4 as ldi; T5 Zlow_out, MAR_in; T6 Read, MDR_in; T7 MDR_out, Gra, Rin.
REQ-016 st (00010): T3-T5 as ld; T6 Gra, Rout, MDR_in; T7 Write.
REQ-017 mul/div (01111/10000): T3 Gra, Rout, Y_in; T4 Grb, Rout, Z_in, alu=opcode; T5 Zlow_out, LO_in; T6 Zhigh_out, HI_in.
REQ-018 neg/not (10001/10010): T3 Grb, Rout, Z_in, alu=opcode; T4 Zlow_out, Gra, Rin.
REQ-019 br (10011): T3 Gra, Rout, CON_in; T4 PC_out, Y_in; T5 C_out, Z_in, alu=00011; T6 Zlow_out, and PC_in only if CON_out sampled at T6 is 1.
REQ-020 jr (10100): T3 Gra, Rout, PC_in; in: T3 InPort_out, Gra, Rin; out: T3 Gra, Rout, OutPort_in; mfhi/mflo: T3 HI_out/LO_out, Gra, Rin.
REQ-021 nop (11010) and every unlisted opcode SHALL return T2->T0 with no execute steps.
REQ-022 halt (11011) SHALL go T2->HALT; HALT drives all strobes 0, Run 0, and persists until clr.
REQ-023 After an instruction's last step the next state SHALL be T0; a step sequence never exceeds T7.
REQ-024 Cycles per instruction: reg/imm/ldi 6, ld/st 8, mul/div/br 7, neg/not 5, single-step ops 4, nop 3.

Reset
REQ-025 clr sampled high at posedge SHALL force RST regardless of state, including mid-ld/st; no Read/Write/Rin/PC_in asserted in RST.
REQ-026 In RST all outputs SHALL be 0 and Run 1; first clock with clr low moves RST->T0.

Structure
REQ-027 Opcode constants, ALU codes, and the step-state enum SHALL live in the shared package minisrc_pkg.
REQ-028 Opcode-to-class decode SHALL be one combinational sub-module ctrl_decode; sequencer and output logic stay in control_unit.

Verification
REQ-029 IR=0x69180025 (andi R2,R3,0x25): T3 Grb+Rout+Y_in, T4 C_out+Z_in+alu=00101, T5 Zlow_out+Gra+Rin, T0 on cycle 7.
REQ-030 IR=0x00800055 (ld): T5 Zlow_out+MAR_in, T6 Read+MDR_in, T7 MDR_out+Gra+Rin, 8 cycles total.
REQ-031 br with CON_out=1 then repeated with 0: PC_in high at T6 only in the first run; both return to T0.
REQ-032 IR=0xD8000000 (halt): after T2 Run=0, all strobes 0 for 20 cycles; clr pulse -> RST -> T0.
REQ-033 clr asserted at st T6: next cycle RST, Write never asserted; opcode 11111 -> T0 after T2.
